w_xor_accum: RTL and testbench
==============================

# w_xor_accum

Parametrised, registered successor to the quad 2-input XOR gate package. It computes a WIDTH-bit bitwise XOR or XNOR of two operand buses, either per beat (pass mode) or folded over a multi-beat frame (accumulate mode, a running XOR checksum). It sits between the lab's input switch/register stage and the output display logic, and replaces the combinational gate block wherever a clocked, framed result is needed.

## Interface
Parameters:
- WIDTH, 4, operand/result width in bits (≥1)
- CNT_W, 8, beat-counter width in bits (≥2)

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- CLR  in  1  synchronous abort/clear, highest priority after reset
- IN_VALID  in  1  A/B/MODE/LAST qualify this cycle
- MODE  in  2  00 XOR pass, 01 XNOR pass, 10 accumulate XOR, 11 accumulate XNOR
- LAST  in  1  final beat of an accumulate frame
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Y  out  WIDTH  registered result
- OUT_VALID  out  1  one-cycle pulse: Y updated this cycle
- BUSY  out  1  state ≠ IDLE
- CNT  out  CNT_W  beats in current/last frame
- OVF  out  1  sticky: CNT saturated in current/last frame
- PARITY  out  1  XOR-reduction of Y (see Configuration)

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, ACCUM, DONE. Internal register ACC[WIDTH-1:0]; latched invert flag INV.
- Reset (RST_N=0): state=IDLE, ACC=0, Y=0, OUT_VALID=0, CNT=0, OVF=0, PARITY=0, BUSY=0, INV=0.
- CLR=1 (any state): same values as reset on the next edge; IN_VALID that cycle is ignored.
- IDLE, IN_VALID, MODE=00/01: Y ← A^B (inverted if MODE[0]); OUT_VALID=1; CNT←1; OVF←0; stay IDLE. A new beat may be accepted every cycle.
- IDLE, IN_VALID, MODE=1x, LAST=0: ACC ← A^B; INV ← MODE[0]; CNT←1; OVF←0; go to ACCUM.
- IDLE, IN_VALID, MODE=1x, LAST=1 (single-beat frame): Y ← (A^B) inverted if MODE[0]; OUT_VALID=1; CNT←1; OVF←0; go to DONE.
- ACCUM, IN_VALID: ACC ← ACC^A^B; CNT ← CNT+1, saturating at 2^CNT_W−1. An increment attempted at saturation sets OVF. MODE is ignored in ACCUM.
- ACCUM, IN_VALID, LAST=1: Y ← final ACC^A^B, inverted if INV; OUT_VALID=1; go to DONE.
- ACCUM, IN_VALID=0: hold all state; no timeout.
- DONE: lasts exactly one cycle; IN_VALID is ignored; ACC←0; returns to IDLE.
- Y, CNT and OVF hold their values until the next output/frame start. Only a frame start or a pass beat clears CNT/OVF.

## Timing
- Pass mode: latency 1 cycle from the IN_VALID edge to Y/OUT_VALID; throughput 1 beat per cycle.
- Accumulate: Y/OUT_VALID follow the edge sampling LAST. The next frame may begin 2 cycles after the LAST beat (DONE bubble).
- OUT_VALID is high for exactly one cycle per result.
- BUSY is registered and is high in ACCUM and DONE.
- PARITY is registered and is updated on the same edge as Y.
- RST_N assertion mid-frame clears all outputs immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Configuration
- W_XOR_ACCUM_PARITY_EN defined: PARITY = ^Y, registered alongside Y, with reset value 0.
- Not defined: PARITY is tied to 0 and no parity logic is synthesised. All other behaviour is identical.

## Test plan
- Reset/pass (WIDTH=4): after reset, Y=0 and CNT=0. Apply A=4'b1010, B=4'b0110, MODE=00, IN_VALID for 1 cycle → next cycle Y=4'b1100, OUT_VALID=1 for 1 cycle, CNT=1. Repeat with MODE=01 → Y=4'b0011.
- Back-to-back pass: 4 consecutive beats of A=0..3 with B=4'hF → Y sequence F,E,D,C on consecutive cycles; OUT_VALID stays high for 4 cycles.
- Accumulate frame: MODE=10, beats (A,B)=(1,0),(2,0),(4,8) with LAST on the third → Y=4'hF, CNT=3, BUSY high for 3 cycles. IN_VALID asserted in the DONE cycle is ignored. MODE=11 with the same data → Y=4'h0.
- Single-beat frame and stalls: MODE=10, LAST=1 on the first beat with A=5, B=0 → Y=5, CNT=1, state passes through DONE. A frame with IN_VALID gaps between beats → result unchanged.
- Saturation (CNT_W=2): a 5-beat frame → CNT=3, OVF=1. OVF clears at the next frame start.
- Abort: CLR in mid-frame → next cycle IDLE, Y=0, CNT=0, no OUT_VALID. RST_N pulsed low mid-frame with no clock edge → outputs 0 immediately. With W_XOR_ACCUM_PARITY_EN defined, Y=4'b0111 → PARITY=1; without the macro, PARITY=0.

Source files
------------

// File: rtl/w_xor_accum.sv
// w_xor_accum: registered XOR/XNOR of two buses, per beat (pass) or folded over a frame (accumulate).
// Define W_XOR_ACCUM_PARITY_EN to add a registered parity bit of Y; otherwise parity_o is tied low.
module w_xor_accum #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             in_valid_i,
    input  logic [1:0]       mode_i,
    input  logic             last_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
    output logic             out_valid_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o,
    output logic             parity_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q, y_q;
    logic             inv_q, out_valid_q, busy_q, ovf_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] ab, acc_d, y_d;
    logic             y_load;

    assign ab    = a_i ^ b_i;
    assign acc_d = acc_q ^ ab;

    // Result load decision shared by the FSM and the optional parity register.
    always_comb begin
        y_load = 1'b0;
        y_d    = y_q;
        if (!clr_i && in_valid_i) begin
            if (state_q == IDLE && (!mode_i[1] || last_i)) begin
                y_load = 1'b1;
                y_d    = ab ^ {WIDTH{mode_i[0]}};
            end else if (state_q == ACCUM && last_i) begin
                y_load = 1'b1;
                y_d    = acc_d ^ {WIDTH{inv_q}};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            y_q         <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else if (clr_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            y_q         <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= y_load;
            if (y_load) y_q <= y_d;
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        cnt_q <= CNT_ONE;
                        ovf_q <= 1'b0;
                        if (mode_i[1]) begin
                            inv_q  <= mode_i[0];
                            busy_q <= 1'b1;
                            if (last_i) begin
                                state_q <= DONE;
                            end else begin
                                acc_q   <= ab;
                                state_q <= ACCUM;
                            end
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid_i) begin
                        acc_q <= acc_d;
                        // Saturate instead of wrapping; the lost beat is flagged sticky.
                        if (cnt_q == CNT_MAX) ovf_q <= 1'b1;
                        else                  cnt_q <= cnt_q + CNT_ONE;
                        if (last_i) state_q <= DONE;
                    end
                end
                DONE: begin
                    acc_q   <= '0;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef W_XOR_ACCUM_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)    parity_q <= 1'b0;
        else if (clr_i)  parity_q <= 1'b0;
        else if (y_load) parity_q <= ^y_d;
    end

    assign parity_o = parity_q;
`else
    assign parity_o = 1'b0;
`endif

    assign y_o         = y_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign cnt_o       = cnt_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_w_xor_accum.sv
// Scoreboard bench for w_xor_accum: frame-level reference model, directed cases then random traffic.
module tb_w_xor_accum;
    localparam int W   = 4;
    localparam int CW  = 2;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0, rst_n = 1'b0, clr = 1'b0, iv = 1'b0, last = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [W-1:0]  a = '0, b = '0;
    logic [W-1:0]  y;
    logic          ov, busy, ovf, par;
    logic [CW-1:0] cnt;

    int checks = 0, errors = 0;

    typedef struct {
        logic [W-1:0] y;
        int           cnt;
        logic         ovf;
    } exp_t;
    exp_t sb[$];

    // Reference model: frame-level view (beats seen so far, running xor, dead cycle after a frame).
    int           fbeats = 0;
    logic [W-1:0] fxor   = '0;
    logic         finv   = 1'b0;
    bit           bubble = 1'b0;
    logic [W-1:0] ey     = '0;
    int           ecnt   = 0;
    logic         eovf   = 1'b0;
    logic         eov    = 1'b0;

    always #5 clk = ~clk;

    w_xor_accum #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .in_valid_i(iv), .mode_i(mode),
        .last_i(last), .a_i(a), .b_i(b), .y_o(y), .out_valid_o(ov), .busy_o(busy),
        .cnt_o(cnt), .ovf_o(ovf), .parity_o(par)
    );

    function automatic logic par_of(input logic [W-1:0] v);
`ifdef W_XOR_ACCUM_PARITY_EN
        return ^v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check registered outputs just after the edge.
    task automatic cycle(input bit v, input logic [1:0] m, input bit l,
                         input logic [W-1:0] aa, input logic [W-1:0] bb, input bit c);
        exp_t e;
        iv = v; mode = m; last = l; a = aa; b = bb; clr = c;
        eov = 1'b0;
        if (c) begin
            fbeats = 0; bubble = 0; ey = '0; ecnt = 0; eovf = 1'b0;
        end else if (bubble) begin
            bubble = 0;
        end else if (fbeats > 0) begin
            if (v) begin
                fbeats++;
                fxor = fxor ^ aa ^ bb;
                ecnt = (fbeats > SAT) ? SAT : fbeats;
                eovf = (fbeats > SAT);
                if (l) begin
                    ey = fxor ^ {W{finv}};
                    eov = 1'b1; fbeats = 0; bubble = 1;
                end
            end
        end else if (v) begin
            ecnt = 1; eovf = 1'b0;
            if (!m[1]) begin
                ey = aa ^ bb ^ {W{m[0]}};
                eov = 1'b1;
            end else begin
                fxor = aa ^ bb; finv = m[0];
                if (l) begin
                    ey = fxor ^ {W{finv}};
                    eov = 1'b1; bubble = 1;
                end else begin
                    fbeats = 1;
                end
            end
        end
        if (eov) begin
            e.y = ey; e.cnt = ecnt; e.ovf = eovf;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        chk("busy", 32'(busy), 32'(fbeats > 0 || bubble));
        chk("out_valid", 32'(ov), 32'(eov));
        chk("y", 32'(y), 32'(ey));
        chk("cnt", 32'(cnt), 32'(ecnt));
        chk("ovf", 32'(ovf), 32'(eovf));
        chk("parity", 32'(par), 32'(par_of(ey)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 2'b00, 0, '0, '0, 0);
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected: out_valid with empty scoreboard, y=%0h", y);
            end else begin
                e = sb.pop_front();
                chk("sb_y", 32'(y), 32'(e.y));
                chk("sb_cnt", 32'(cnt), 32'(e.cnt));
                chk("sb_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        #12;
        chk("rst_y", 32'(y), 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ov", 32'(ov), 0);
        chk("rst_par", 32'(par), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // pass XOR / XNOR, then four back-to-back beats
        cycle(1, 2'b00, 0, 4'b1010, 4'b0110, 0);
        cycle(1, 2'b01, 0, 4'b1010, 4'b0110, 0);
        idle(1);
        for (int i = 0; i < 4; i++) cycle(1, 2'b00, 0, 4'(i), 4'hF, 0);
        idle(1);

        // accumulate XOR frame, with a beat offered during the dead cycle
        cycle(1, 2'b10, 0, 4'd1, 4'd0, 0);
        cycle(1, 2'b10, 0, 4'd2, 4'd0, 0);
        cycle(1, 2'b10, 1, 4'd4, 4'd8, 0);
        cycle(1, 2'b00, 0, 4'd9, 4'd3, 0);
        idle(1);
        // accumulate XNOR frame
        cycle(1, 2'b11, 0, 4'd1, 4'd0, 0);
        cycle(1, 2'b11, 0, 4'd2, 4'd0, 0);
        cycle(1, 2'b11, 1, 4'd4, 4'd8, 0);
        idle(2);

        // single-beat frame, then a frame with stalls and a changing (ignored) mode
        cycle(1, 2'b10, 1, 4'd5, 4'd0, 0);
        idle(2);
        cycle(1, 2'b10, 0, 4'd3, 4'd0, 0);
        idle(2);
        cycle(1, 2'b01, 0, 4'd5, 4'd9, 0);
        idle(1);
        cycle(1, 2'b00, 1, 4'd6, 4'd6, 0);
        idle(2);

        // saturation: five beats on a 2-bit counter, then a pass beat clears OVF
        for (int i = 0; i < 5; i++) cycle(1, 2'b10, (i == 4), 4'(i + 1), 4'd0, 0);
        idle(2);
        cycle(1, 2'b00, 0, 4'd7, 4'd0, 0);
        idle(1);

        // synchronous abort mid-frame
        cycle(1, 2'b10, 0, 4'd7, 4'd0, 0);
        cycle(1, 2'b10, 1, 4'd1, 4'd1, 1);
        idle(2);

        // asynchronous reset mid-frame, checked before any further clock edge
        cycle(1, 2'b00, 0, 4'b0111, 4'd0, 0);
        cycle(1, 2'b10, 0, 4'd3, 4'd0, 0);
        iv = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("arst_y", 32'(y), 0);
        chk("arst_ov", 32'(ov), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_cnt", 32'(cnt), 0);
        chk("arst_ovf", 32'(ovf), 0);
        chk("arst_par", 32'(par), 0);
        #2;
        rst_n = 1'b1;
        fbeats = 0; bubble = 0; ey = '0; ecnt = 0; eovf = 1'b0;
        sb.delete();
        @(posedge clk); #1;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(99) < 70, 2'($urandom_range(3)), $urandom_range(99) < 30,
                  4'($urandom), 4'($urandom), $urandom_range(99) < 2);
        end
        idle(3);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
